sdram_burst_responder: RTL and testbench

SDRAM_BURST_RESPONDER -- requirements
Module: sdram_burst_responder

---
 rtl/sdram_burst_responder.sv | 135 +++++++++++++
 tb/tb_sdram_burst_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_responder.sv
// Avalon-style SDRAM slave model: 256-bit on-chip RAM answering write and read bursts,
// with fixed read latency, optional pseudo-random wait-request insertion and a sticky error flag.
module sdram_burst_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 2,
    parameter bit STALL_EN     = 1'b0
) (
    input  logic         ipClk,
    input  logic         ipReset,
    output logic         opSDRAM_WaitRequest,
    input  logic [26:0]  ipSDRAM_Address,
    input  logic [31:0]  ipSDRAM_ByteEnable,
    input  logic [7:0]   ipSDRAM_BurstCount,
    input  logic [255:0] ipSDRAM_WriteData,
    input  logic         ipSDRAM_Write,
    input  logic         ipSDRAM_Read,
    output logic [255:0] opSDRAM_ReadData,
    output logic         opSDRAM_ReadValid,
    output logic         opBusy,
    output logic         opError
);

    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  WRITE_BURST = 2'd1;
    localparam logic [1:0]  READ_BURST  = 2'd2;
    localparam int          DEPTH       = 1 << ADDR_BITS;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] base;
    logic [7:0]           len;
    logic [7:0]           beat;
    logic [9:0]           tick;
    logic                 ready;
    logic [15:0]          lfsr;
    logic [255:0]         mem [DEPTH];

    logic                 stall;
    logic [ADDR_BITS-1:0] addr_low;
    logic [ADDR_BITS-1:0] idx;
    logic [7:0]           first_len;
    logic                 accept_wr;
    logic                 accept_rd;
    logic [9:0]           next_tick;
    logic                 issue;
    logic                 lfsr_fb;

    generate
        if (ADDR_BITS < 27) begin : g_upper
            logic unused_addr_bits;
            assign unused_addr_bits = ^ipSDRAM_Address[26:ADDR_BITS];
        end
    endgenerate

    // ready is a flop so WaitRequest cannot drop until the first edge after reset release.
    assign stall               = STALL_EN && lfsr[0];
    assign opSDRAM_WaitRequest = !ready || (state == READ_BURST) || stall;
    assign opBusy              = (state != IDLE);

    assign addr_low  = ipSDRAM_Address[ADDR_BITS-1:0];
    assign first_len = (ipSDRAM_BurstCount == 8'd0) ? 8'd1 : ipSDRAM_BurstCount;
    assign accept_wr = ipSDRAM_Write && !opSDRAM_WaitRequest;
    assign accept_rd = ipSDRAM_Read && !ipSDRAM_Write && !opSDRAM_WaitRequest && (state == IDLE);
    assign idx       = (state == IDLE) ? addr_low : base + ADDR_BITS'(beat);
    assign next_tick = (state == IDLE) ? 10'd1 : tick + 10'd1;
    assign issue     = (state == IDLE) ? (accept_rd && (READ_LATENCY == 1))
                                       : ((state == READ_BURST) && (next_tick >= 10'(READ_LATENCY))
                                          && (beat != len));
    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // NOTE: the RAM has no reset branch on purpose; its contents must survive a reset.
    always_ff @(posedge ipClk) begin
        if (accept_wr) begin
            for (int i = 0; i < 32; i++) begin
                if (ipSDRAM_ByteEnable[i]) mem[idx][i*8 +: 8] <= ipSDRAM_WriteData[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state             <= IDLE;
            base              <= '0;
            len               <= '0;
            beat              <= '0;
            tick              <= '0;
            ready             <= 1'b0;
            lfsr              <= LFSR_SEED;
            opSDRAM_ReadValid <= 1'b0;
            opSDRAM_ReadData  <= '0;
            opError           <= 1'b0;
        end else begin
            ready             <= 1'b1;
            lfsr              <= {lfsr_fb, lfsr[15:1]};
            opSDRAM_ReadValid <= issue;
            if (issue) opSDRAM_ReadData <= mem[idx];

            if (ipSDRAM_Read && ((state == WRITE_BURST) || ((state == IDLE) && accept_wr)))
                opError <= 1'b1;
            if ((state == IDLE) && (accept_wr || accept_rd) && (ipSDRAM_BurstCount == 8'd0))
                opError <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        base <= addr_low;
                        len  <= first_len;
                        beat <= 8'd1;
                        if (first_len != 8'd1) state <= WRITE_BURST;
                    end else if (accept_rd) begin
                        base  <= addr_low;
                        len   <= first_len;
                        tick  <= 10'd1;
                        beat  <= issue ? 8'd1 : 8'd0;
                        state <= READ_BURST;
                    end
                end
                WRITE_BURST: begin
                    if (accept_wr) begin
                        beat <= beat + 8'd1;
                        if (beat + 8'd1 == len) state <= IDLE;
                    end
                end
                READ_BURST: begin
                    tick <= next_tick;
                    if (issue) beat <= beat + 8'd1;
                    // All beats issued means the last ReadValid is on the bus this cycle.
                    if (beat == len) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed and randomized bench for sdram_burst_responder: one instance without stalls
// (latency 2) and one with LFSR stalls (latency 3), both checked against a word-array model.
module tb_sdram_burst_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]        wr, rd, wait_req, rvalid, busy, err;
    logic [1:0][26:0]  addr;
    logic [1:0][31:0]  be;
    logic [1:0][7:0]   bc;
    logic [1:0][255:0] wdata, rdata;

    sdram_burst_responder #(.ADDR_BITS(10), .READ_LATENCY(2), .STALL_EN(1'b0)) dut0 (
        .ipClk(clk), .ipReset(rst_n), .opSDRAM_WaitRequest(wait_req[0]),
        .ipSDRAM_Address(addr[0]), .ipSDRAM_ByteEnable(be[0]), .ipSDRAM_BurstCount(bc[0]),
        .ipSDRAM_WriteData(wdata[0]), .ipSDRAM_Write(wr[0]), .ipSDRAM_Read(rd[0]),
        .opSDRAM_ReadData(rdata[0]), .opSDRAM_ReadValid(rvalid[0]), .opBusy(busy[0]), .opError(err[0])
    );

    sdram_burst_responder #(.ADDR_BITS(10), .READ_LATENCY(3), .STALL_EN(1'b1)) dut1 (
        .ipClk(clk), .ipReset(rst_n), .opSDRAM_WaitRequest(wait_req[1]),
        .ipSDRAM_Address(addr[1]), .ipSDRAM_ByteEnable(be[1]), .ipSDRAM_BurstCount(bc[1]),
        .ipSDRAM_WriteData(wdata[1]), .ipSDRAM_Write(wr[1]), .ipSDRAM_Read(rd[1]),
        .opSDRAM_ReadData(rdata[1]), .opSDRAM_ReadValid(rvalid[1]), .opBusy(busy[1]), .opError(err[1])
    );

    int           checks = 0;
    int           errors = 0;
    int           stall_seen = 0;
    logic [255:0] model_mem [2][1024];
    logic [1:0]   exp_err = 2'b00;
    logic [255:0] wbuf [256];
    logic [31:0]  wbe  [256];

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int widx(input logic [26:0] a, input int k);
        return (int'(a[9:0]) + k) % 1024;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] data,
                                           input logic [31:0] en);
        logic [255:0] res;
        res = old;
        for (int i = 0; i < 32; i++) if (en[i]) res[i*8 +: 8] = data[i*8 +: 8];
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with a request driven; returns at the negedge before the accepting edge.
    task automatic wait_ready(input int d, input string tag);
        int n;
        n = 0;
        while (wait_req[d] && n < 200) begin
            stall_seen++;
            @(negedge clk);
            n++;
        end
        check_bit({tag, "_accept"}, (d == 0) ? (n == 0) : (n < 200), 1'b1);
    endtask

    task automatic do_write(input int d, input logic [26:0] a, input int beats, input int field,
                            input int rd_mode, input bit gaps, input string tag);
        for (int k = 0; k < beats; k++) begin
            wr[d]    = 1'b1;
            addr[d]  = a;
            bc[d]    = 8'(field);
            wdata[d] = wbuf[k];
            be[d]    = wbe[k];
            rd[d]    = (rd_mode == 1 && k == 0) || (rd_mode == 2 && k > 0);
            wait_ready(d, tag);
            @(negedge clk);
            model_mem[d][widx(a, k)] = merge(model_mem[d][widx(a, k)], wbuf[k], wbe[k]);
            if (rd[d]) exp_err[d] = 1'b1;
            if (k == 0 && field == 0) exp_err[d] = 1'b1;
            wr[d] = 1'b0;
            rd[d] = 1'b0;
            check_bit({tag, "_busy"}, busy[d], k < beats - 1);
            if (gaps && k < beats - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check_bit({tag, "_err"}, err[d], exp_err[d]);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_bit("rst_wait", wait_req[d], 1'b1);
            check_bit("rst_valid", rvalid[d], 1'b0);
            check_word("rst_data", rdata[d], '0);
            check_bit("rst_busy", busy[d], 1'b0);
            check_bit("rst_err", err[d], 1'b0);
        end
        exp_err = 2'b00;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        check_bit("release_wait_held", wait_req[0], 1'b1);
        @(negedge clk);
        check_bit("release_wait_low", wait_req[0], 1'b0);
        for (int d = 0; d < 2; d++) begin
            check_bit("release_busy", busy[d], 1'b0);
            check_bit("release_valid", rvalid[d], 1'b0);
        end
    endtask

    task automatic do_read(input int d, input logic [26:0] a, input int n, input int abort_at,
                           input string tag);
        int  l;
        bit  exp_v;
        l = lat(d);
        rd[d]   = 1'b1;
        addr[d] = a;
        bc[d]   = 8'(n);
        wait_ready(d, tag);
        @(negedge clk);
        rd[d] = 1'b0;
        for (int c = 1; c <= l + n; c++) begin
            if (c > 1) @(negedge clk);
            exp_v = (c >= l) && (c < l + n);
            check_bit({tag, "_valid"}, rvalid[d], exp_v);
            if (exp_v) check_word({tag, "_data"}, rdata[d], model_mem[d][widx(a, c - l)]);
            check_bit({tag, "_busy"}, busy[d], c < l + n);
            if (c < l + n) check_bit({tag, "_wait_in_burst"}, wait_req[d], 1'b1);
            else if (d == 0) check_bit({tag, "_wait_idle"}, wait_req[d], 1'b0);
            if (abort_at > 0 && c == l + abort_at - 1) begin
                assert_reset();
                return;
            end
        end
        check_bit({tag, "_err"}, err[d], exp_err[d]);
    endtask

    initial begin
        int           d;
        int           n;
        logic [26:0]  a;

        wr = '0; rd = '0; addr = '0; be = '0; bc = '0; wdata = '0;
        #2;
        assert_reset();
        repeat (2) @(negedge clk);
        release_reset();

        // Four-beat write then read back at latency 2.
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = 256'(k * 32'h1111);
            wbe[k]  = '1;
        end
        do_write(0, 27'h10, 4, 4, 0, 1'b0, "burst4_wr");
        do_read(0, 27'h10, 4, 0, "burst4_rd");

        // Byte-enable merge over an all-ones word.
        wbuf[0] = '1;
        wbe[0]  = '1;
        do_write(0, 27'h20, 1, 1, 0, 1'b0, "be_fill");
        wbuf[0] = '0;
        wbe[0]  = 32'h0000_0001;
        do_write(0, 27'h20, 1, 1, 0, 1'b0, "be_byte0");
        do_read(0, 27'h20, 1, 0, "be_rd");

        // Address wrap at the top of RAM; upper address bits are ignored.
        for (int k = 0; k < 3; k++) begin
            wbuf[k] = rand256();
            wbe[k]  = '1;
        end
        do_write(0, {17'h1ABCD, 10'h3FF}, 3, 3, 0, 1'b1, "wrap_wr");
        do_read(0, 27'h3FF, 1, 0, "wrap_rd3ff");
        do_read(0, 27'h000, 1, 0, "wrap_rd000");
        do_read(0, 27'h001, 1, 0, "wrap_rd001");
        do_read(0, {17'h00042, 10'h3FF}, 3, 0, "wrap_rdburst");

        // Simultaneous Read and Write in IDLE: write wins, error latches.
        wbuf[0] = rand256();
        wbe[0]  = '1;
        do_write(0, 27'h40, 1, 1, 1, 1'b0, "rw_both");
        do_read(0, 27'h40, 1, 0, "rw_both_rd");

        // Reset after two of eight read beats; RAM survives and a new burst works.
        do_read(0, 27'h10, 8, 2, "abort_rd");
        repeat (2) @(negedge clk);
        check_bit("abort_no_valid", rvalid[0], 1'b0);
        release_reset();
        do_read(0, 27'h10, 4, 0, "after_abort_rd");

        // BurstCount of zero behaves as a single beat and flags an error.
        wbuf[0] = rand256();
        wbe[0]  = '1;
        do_write(0, 27'h50, 1, 0, 0, 1'b0, "count0_wr");
        do_read(0, 27'h50, 1, 0, "count0_rd");

        // Read asserted during a write burst is ignored but flagged.
        assert_reset();
        repeat (2) @(negedge clk);
        release_reset();
        for (int k = 0; k < 5; k++) begin
            wbuf[k] = rand256();
            wbe[k]  = '1;
        end
        do_write(0, 27'h60, 5, 5, 2, 1'b1, "rd_in_wr");
        do_read(0, 27'h60, 5, 0, "rd_in_wr_rd");

        assert_reset();
        repeat (2) @(negedge clk);
        release_reset();

        // 64-beat write with stalls enabled.
        stall_seen = 0;
        for (int k = 0; k < 64; k++) begin
            wbuf[k] = rand256();
            wbe[k]  = '1;
        end
        do_write(1, 27'h200, 64, 64, 0, 1'b0, "stall_wr64");
        check_bit("stall_seen", stall_seen > 0, 1'b1);
        do_read(1, 27'h200, 64, 0, "stall_rd64");

        // Randomized traffic over a prefilled window on both instances.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 128; k++) begin
                wbuf[k] = rand256();
                wbe[k]  = '1;
            end
            do_write(i, 27'h100, 128, 128, 0, 1'b0, "prefill");
        end
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(1, 8);
            a = {17'($urandom()), 10'(32'h100 + $urandom_range(0, 'h78))};
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) begin
                    wbuf[k] = rand256();
                    wbe[k]  = $urandom();
                end
                do_write(d, a, n, n, 0, 1'b1, "rand_wr");
            end else begin
                do_read(d, a, n, 0, "rand_rd");
            end
        end

        check_bit("final_err0", err[0], exp_err[0]);
        check_bit("final_err1", err[1], exp_err[1]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
